data_mem_ctrl: RTL and testbench

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

---
 rtl/data_mem_ctrl.sv | 161 ++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - data memory controller: byte-lane RAM plus LED/switch/timer MMIO window
module data_mem_ctrl #(
   parameter int          DEPTH_WORDS = 256,
   parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_w,
   input  logic [31:0] Addr_in,
   input  logic [31:0] Data_in,
   input  logic [2:0]  DMType,
   output logic [31:0] Data_out,
   input  logic [15:0] sw_in,
   output logic [15:0] led_out,
   output logic        irq,
   output logic        err
);

   localparam int AW = $clog2(DEPTH_WORDS);

   localparam logic [2:0] DM_W  = 3'b000;
   localparam logic [2:0] DM_HS = 3'b001;
   localparam logic [2:0] DM_HU = 3'b010;
   localparam logic [2:0] DM_BS = 3'b011;
   localparam logic [2:0] DM_BU = 3'b100;

   localparam logic [15:0] OFF_LED    = 16'h0000;
   localparam logic [15:0] OFF_SW     = 16'h0004;
   localparam logic [15:0] OFF_TIMER  = 16'h0008;
   localparam logic [15:0] OFF_CMP    = 16'h000C;
   localparam logic [15:0] OFF_STATUS = 16'h0010;

   logic [31:0] mem [DEPTH_WORDS];

   logic [31:0] timer;
   logic [31:0] cmp;

   logic          is_mmio;
   logic [AW-1:0] widx;
   logic [15:0]   off;
   logic          is_word;
   logic          is_half;
   logic          is_byte;
   logic          aligned;
   logic [3:0]    be;
   logic [31:0]   wlanes;
   logic          ram_we;
   logic          mmio_we;
   logic          store_err;
   logic [31:0]   rword;
   logic [7:0]    rbyte;
   logic [15:0]   rhalf;
   logic [31:0]   ram_rdata;
   logic [31:0]   mmio_rdata;

   assign is_mmio = (Addr_in[31:16] == MMIO_BASE[31:16]);
   assign widx    = Addr_in[AW+1:2];
   assign off     = Addr_in[15:0];

   // Classify the access size, alignment and the lanes/data a store would drive
   always_comb begin
      is_word = (DMType == DM_W);
      is_half = (DMType == DM_HS) || (DMType == DM_HU);
      is_byte = (DMType == DM_BS) || (DMType == DM_BU);
      aligned = 1'b0;
      be      = 4'b0000;
      wlanes  = Data_in;
      if (is_word) begin
         aligned = (Addr_in[1:0] == 2'b00);
         be      = 4'b1111;
      end else if (is_half) begin
         aligned = !Addr_in[0];
         be      = Addr_in[1] ? 4'b1100 : 4'b0011;
         wlanes  = {2{Data_in[15:0]}};
      end else if (is_byte) begin
         aligned = 1'b1;
         be      = 4'b0001 << Addr_in[1:0];
         wlanes  = {4{Data_in[7:0]}};
      end
   end

   // Illegal types never count as aligned, so one flag covers both error causes
   assign ram_we    = mem_w && !reset && !is_mmio && aligned;
   assign mmio_we   = mem_w && !reset && is_mmio && is_word;
   assign store_err = mem_w && !reset && (is_mmio ? !is_word : !aligned);

   assign rword = mem[widx];
   assign rbyte = rword[{Addr_in[1:0], 3'b000} +: 8];
   assign rhalf = Addr_in[1] ? rword[31:16] : rword[15:0];

   // RAM load path: lane select followed by sign or zero extension
   always_comb begin
      ram_rdata = 32'h0;
      if (aligned) begin
         case (DMType)
            DM_W:    ram_rdata = rword;
            DM_HS:   ram_rdata = {{16{rhalf[15]}}, rhalf};
            DM_HU:   ram_rdata = {16'h0, rhalf};
            DM_BS:   ram_rdata = {{24{rbyte[7]}}, rbyte};
            DM_BU:   ram_rdata = {24'h0, rbyte};
            default: ram_rdata = 32'h0;
         endcase
      end
   end

   // MMIO load path: word accesses only, unmapped offsets read zero
   always_comb begin
      mmio_rdata = 32'h0;
      if (is_word) begin
         case (off)
            OFF_LED:    mmio_rdata = {16'h0, led_out};
            OFF_SW:     mmio_rdata = {16'h0, sw_in};
            OFF_TIMER:  mmio_rdata = timer;
            OFF_CMP:    mmio_rdata = cmp;
            OFF_STATUS: mmio_rdata = {31'h0, irq};
            default:    mmio_rdata = 32'h0;
         endcase
      end
   end

   assign Data_out = is_mmio ? mmio_rdata : ram_rdata;

   // RAM byte-lane writes; contents are deliberately not reset
   always_ff @(posedge clk) begin
      if (ram_we) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
               mem[widx][8*i +: 8] <= wlanes[8*i +: 8];
            end
         end
      end
   end

   // Peripheral registers, free-running timer, match flag and sticky error
   always_ff @(posedge clk) begin
      if (reset) begin
         led_out <= 16'h0;
         timer   <= 32'h0;
         cmp     <= 32'hFFFF_FFFF;
         irq     <= 1'b0;
         err     <= 1'b0;
      end else begin
         if (store_err) begin
            err <= 1'b1;
         end
         if (mmio_we && (off == OFF_LED)) begin
            led_out <= Data_in[15:0];
         end
         if (mmio_we && (off == OFF_CMP)) begin
            cmp <= Data_in;
         end
         timer <= (mmio_we && (off == OFF_TIMER)) ? Data_in : timer + 32'd1;
         if (timer == cmp) begin
            irq <= 1'b1;
         end else if (mmio_we && (off == OFF_STATUS) && Data_in[0]) begin
            irq <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb/tb_data_mem_ctrl.sv - randomized and directed bench for data_mem_ctrl against a byte-level model
module tb_data_mem_ctrl;

   localparam int DEPTH = 256;
   localparam int NB    = DEPTH * 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_w;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [2:0]  dmt;
   logic [31:0] data_out;
   logic [15:0] sw_in;
   logic [15:0] led_out;
   logic        irq;
   logic        err;

   int checks = 0;
   int errors = 0;

   logic [7:0]  m_ram [NB];
   logic [15:0] m_led;
   logic [31:0] m_timer;
   logic [31:0] m_cmp;
   logic        m_match;
   logic        m_err;

   always #5 clk = ~clk;

   data_mem_ctrl #(.DEPTH_WORDS(DEPTH), .MMIO_BASE(32'hFFFF_0000)) dut (
      .clk      (clk),
      .reset    (reset),
      .mem_w    (mem_w),
      .Addr_in  (addr),
      .Data_in  (wdata),
      .DMType   (dmt),
      .Data_out (data_out),
      .sw_in    (sw_in),
      .led_out  (led_out),
      .irq      (irq),
      .err      (err)
   );

   function automatic logic m_mmio(input logic [31:0] a);
      return a[31:16] == 16'hFFFF;
   endfunction

   function automatic int m_size(input logic [2:0] t);
      case (t)
         3'd0:       return 4;
         3'd1, 3'd2: return 2;
         3'd3, 3'd4: return 1;
         default:    return 0;
      endcase
   endfunction

   function automatic logic m_ok(input logic [31:0] a, input logic [2:0] t);
      int s = m_size(t);
      if (s == 0) return 1'b0;
      return (int'(a[1:0]) % s) == 0;
   endfunction

   function automatic logic [31:0] m_load(input logic [31:0] a, input logic [2:0] t);
      int b;
      logic [15:0] v16;
      logic [7:0]  v8;
      if (m_mmio(a)) begin
         if (t != 3'd0) return 32'h0;
         case (a[15:0])
            16'h0000: return {16'h0, m_led};
            16'h0004: return {16'h0, sw_in};
            16'h0008: return m_timer;
            16'h000C: return m_cmp;
            16'h0010: return {31'h0, m_match};
            default:  return 32'h0;
         endcase
      end
      if (!m_ok(a, t)) return 32'h0;
      b = int'(a % NB);
      case (m_size(t))
         4: return {m_ram[b+3], m_ram[b+2], m_ram[b+1], m_ram[b]};
         2: begin
            v16 = {m_ram[b+1], m_ram[b]};
            return (t == 3'd1) ? {{16{v16[15]}}, v16} : {16'h0, v16};
         end
         default: begin
            v8 = m_ram[b];
            return (t == 3'd3) ? {{24{v8[7]}}, v8} : {24'h0, v8};
         end
      endcase
   endfunction

   function automatic void m_update(input logic r, input logic w, input logic [31:0] a,
                                    input logic [31:0] d, input logic [2:0] t);
      logic hit;
      logic clr;
      logic tload;
      int   b;
      if (r) begin
         m_led = 16'h0; m_timer = 32'h0; m_cmp = 32'hFFFF_FFFF; m_match = 1'b0; m_err = 1'b0;
         return;
      end
      hit = (m_timer == m_cmp);
      clr = 1'b0;
      tload = 1'b0;
      if (w) begin
         if (m_mmio(a)) begin
            if (t != 3'd0) m_err = 1'b1;
            else begin
               case (a[15:0])
                  16'h0000: m_led = d[15:0];
                  16'h0008: tload = 1'b1;
                  16'h000C: m_cmp = d;
                  16'h0010: clr = d[0];
                  default: ;
               endcase
            end
         end else if (!m_ok(a, t)) begin
            m_err = 1'b1;
         end else begin
            b = int'(a % NB);
            for (int i = 0; i < m_size(t); i++) m_ram[b+i] = d[8*i +: 8];
         end
      end
      m_timer = tload ? d : m_timer + 32'd1;
      m_match = hit | (m_match & ~clr);
   endfunction

   task automatic step(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [2:0] t, output logic [31:0] obs, output logic [31:0] exp);
      @(negedge clk);
      reset = r; mem_w = w; addr = a; wdata = d; dmt = t;
      #1;
      obs = data_out;
      exp = m_load(a, t);
      @(posedge clk);
      m_update(r, w, a, d, t);
      #1;
   endtask

   task automatic test_reset();
      logic [31:0] o, e;
      step(1'b1, 1'b1, 32'hFFFF_0000, 32'h1234, 3'd0, o, e);
      step(1'b1, 1'b0, 32'h0, 32'h0, 3'd0, o, e);
      checks++; if (led_out !== 16'h0) begin errors++; $display("FAIL reset_led got %h want 0000", led_out); end
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b want 0", irq); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
      step(1'b0, 1'b0, 32'hFFFF_0008, 32'h0, 3'd0, o, e);
      checks++; if (o !== 32'h0) begin errors++; $display("FAIL reset_timer0 got %h want 00000000", o); end
      step(1'b0, 1'b0, 32'hFFFF_000C, 32'h0, 3'd0, o, e);
      checks++; if (o !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reset_cmp got %h want ffffffff", o); end
      step(1'b0, 1'b0, 32'hFFFF_0008, 32'h0, 3'd0, o, e);
      checks++; if (o !== 32'h2) begin errors++; $display("FAIL reset_timer2 got %h want 00000002", o); end
      for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 32'(i * 4), 32'h0, 3'd0, o, e);
   endtask

   task automatic test_ram_lanes();
      logic [31:0] o, e;
      step(1'b1, 1'b0, 32'h0, 32'h0, 3'd0, o, e);
      step(1'b0, 1'b1, 32'h40, 32'h1122_3344, 3'd0, o, e);
      step(1'b0, 1'b0, 32'h41, 32'h0, 3'd3, o, e);
      checks++; if (o !== 32'h33) begin errors++; $display("FAIL lb_41 got %h want 00000033", o); end
      step(1'b0, 1'b0, 32'h43, 32'h0, 3'd4, o, e);
      checks++; if (o !== 32'h11) begin errors++; $display("FAIL lbu_43 got %h want 00000011", o); end
      step(1'b0, 1'b0, 32'h42, 32'h0, 3'd1, o, e);
      checks++; if (o !== 32'h1122) begin errors++; $display("FAIL lh_42 got %h want 00001122", o); end
      step(1'b0, 1'b1, 32'h80, 32'h0, 3'd0, o, e);
      step(1'b0, 1'b1, 32'h82, 32'hFF, 3'd3, o, e);
      step(1'b0, 1'b0, 32'h80, 32'h0, 3'd0, o, e);
      checks++; if (o !== 32'h00FF_0000) begin errors++; $display("FAIL lw_80 got %h want 00ff0000", o); end
      step(1'b0, 1'b0, 32'h82, 32'h0, 3'd3, o, e);
      checks++; if (o !== 32'hFFFF_FFFF) begin errors++; $display("FAIL lb_82 got %h want ffffffff", o); end
      step(1'b0, 1'b0, 32'h82, 32'h0, 3'd4, o, e);
      checks++; if (o !== 32'hFF) begin errors++; $display("FAIL lbu_82 got %h want 000000ff", o); end
      step(1'b0, 1'b1, 32'h0000_1C40 + 32'(NB), 32'hCAFE_F00D, 3'd0, o, e);
      step(1'b0, 1'b0, 32'h0000_0040, 32'h0, 3'd0, o, e);
      checks++; if (o !== 32'hCAFE_F00D) begin errors++; $display("FAIL wrap_lw got %h want cafef00d", o); end
      step(1'b0, 1'b1, 32'h0000_0040, 32'h1122_3344, 3'd0, o, e);
      step(1'b0, 1'b0, 32'h0000_0040, 32'h0, 3'd0, o, e);
      checks++; if (o !== 32'h1122_3344) begin errors++; $display("FAIL sw_same_cycle got %h want 11223344", o); end
   endtask

   task automatic test_misaligned();
      logic [31:0] o, e;
      step(1'b1, 1'b0, 32'h0, 32'h0, 3'd0, o, e);
      step(1'b0, 1'b1, 32'h41, 32'hAAAA, 3'd1, o, e);
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sh_41 got %b want 1", err); end
      step(1'b0, 1'b0, 32'h40, 32'h0, 3'd0, o, e);
      checks++; if (o !== 32'h1122_3344) begin errors++; $display("FAIL ram_after_sh got %h want 11223344", o); end
      step(1'b0, 1'b1, 32'h42, 32'h0, 3'd0, o, e);
      step(1'b0, 1'b0, 32'h40, 32'h0, 3'd0, o, e);
      checks++; if (o !== 32'h1122_3344) begin errors++; $display("FAIL ram_after_sw got %h want 11223344", o); end
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_held got %b want 1", err); end
      step(1'b0, 1'b0, 32'h41, 32'h0, 3'd1, o, e);
      checks++; if (o !== 32'h0) begin errors++; $display("FAIL lh_misaligned got %h want 00000000", o); end
      step(1'b0, 1'b0, 32'h40, 32'h0, 3'd6, o, e);
      checks++; if (o !== 32'h0) begin errors++; $display("FAIL ld_illegal got %h want 00000000", o); end
      step(1'b1, 1'b0, 32'h0, 32'h0, 3'd0, o, e);
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_cleared got %b want 0", err); end
   endtask

   task automatic test_timer();
      logic [31:0] o, e;
      step(1'b1, 1'b0, 32'h0, 32'h0, 3'd0, o, e);
      step(1'b0, 1'b1, 32'hFFFF_000C, 32'h0, 3'd0, o, e);
      step(1'b0, 1'b1, 32'hFFFF_0008, 32'hFFFF_FFFE, 3'd0, o, e);
      step(1'b0, 1'b0, 32'hFFFF_0008, 32'h0, 3'd0, o, e);
      checks++; if (o !== 32'hFFFF_FFFE) begin errors++; $display("FAIL timer_load got %h want fffffffe", o); end
      step(1'b0, 1'b0, 32'hFFFF_0008, 32'h0, 3'd0, o, e);
      checks++; if (o !== 32'hFFFF_FFFF) begin errors++; $display("FAIL timer_max got %h want ffffffff", o); end
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_early got %b want 0", irq); end
      step(1'b0, 1'b0, 32'hFFFF_0008, 32'h0, 3'd0, o, e);
      checks++; if (o !== 32'h0) begin errors++; $display("FAIL timer_wrap got %h want 00000000", o); end
      checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_match got %b want 1", irq); end
      step(1'b0, 1'b1, 32'hFFFF_0010, 32'h1, 3'd0, o, e);
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_w1c got %b want 0", irq); end
      step(1'b0, 1'b1, 32'hFFFF_000C, m_timer + 32'd2, 3'd0, o, e);
      step(1'b0, 1'b0, 32'h0, 32'h0, 3'd0, o, e);
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_pre got %b want 0", irq); end
      step(1'b0, 1'b1, 32'hFFFF_0010, 32'h1, 3'd0, o, e);
      checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_set_prio got %b want 1", irq); end
      step(1'b0, 1'b1, 32'hFFFF_0010, 32'h1, 3'd0, o, e);
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear2 got %b want 0", irq); end
   endtask

   task automatic test_mmio();
      logic [31:0] o, e;
      step(1'b1, 1'b0, 32'h0, 32'h0, 3'd0, o, e);
      step(1'b0, 1'b1, 32'hFFFF_0000, 32'hABCD_1234, 3'd0, o, e);
      checks++; if (led_out !== 16'h1234) begin errors++; $display("FAIL led_sw got %h want 1234", led_out); end
      step(1'b0, 1'b1, 32'hFFFF_0000, 32'hFF, 3'd3, o, e);
      checks++; if (led_out !== 16'h1234) begin errors++; $display("FAIL led_sb got %h want 1234", led_out); end
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_mmio_sb got %b want 1", err); end
      sw_in = 16'h5A5A;
      step(1'b0, 1'b0, 32'hFFFF_0004, 32'h0, 3'd0, o, e);
      checks++; if (o !== 32'h0000_5A5A) begin errors++; $display("FAIL sw_read got %h want 00005a5a", o); end
      step(1'b0, 1'b0, 32'hFFFF_0000, 32'h0, 3'd0, o, e);
      checks++; if (o !== 32'h0000_1234) begin errors++; $display("FAIL led_read got %h want 00001234", o); end
      step(1'b0, 1'b0, 32'hFFFF_0014, 32'h0, 3'd0, o, e);
      checks++; if (o !== 32'h0) begin errors++; $display("FAIL unmapped got %h want 00000000", o); end
      step(1'b0, 1'b0, 32'hFFFF_0004, 32'h0, 3'd4, o, e);
      checks++; if (o !== 32'h0) begin errors++; $display("FAIL mmio_lbu got %h want 00000000", o); end
   endtask

   task automatic test_reset_midrun();
      logic [31:0] o, e;
      step(1'b0, 1'b1, 32'h100, 32'h1234_5678, 3'd0, o, e);
      step(1'b0, 1'b1, 32'hFFFF_0000, 32'h00FF, 3'd0, o, e);
      step(1'b0, 1'b1, 32'hFFFF_000C, m_timer + 32'd1, 3'd0, o, e);
      step(1'b0, 1'b1, 32'hFFFF_0000, 32'h1, 3'd1, o, e);
      checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_before_rst got %b want 1", irq); end
      step(1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 3'd0, o, e);
      step(1'b1, 1'b1, 32'hFFFF_0000, 32'hFFFF, 3'd0, o, e);
      checks++; if (led_out !== 16'h0) begin errors++; $display("FAIL mid_led got %h want 0000", led_out); end
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL mid_irq got %b want 0", irq); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL mid_err got %b want 0", err); end
      step(1'b0, 1'b0, 32'hFFFF_0008, 32'h0, 3'd0, o, e);
      checks++; if (o !== 32'h0) begin errors++; $display("FAIL mid_timer got %h want 00000000", o); end
      step(1'b0, 1'b0, 32'h100, 32'h0, 3'd0, o, e);
      checks++; if (o !== 32'h1234_5678) begin errors++; $display("FAIL mid_ram got %h want 12345678", o); end
      step(1'b0, 1'b0, 32'hFFFF_000C, 32'h0, 3'd0, o, e);
      checks++; if (o !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mid_cmp got %h want ffffffff", o); end
   endtask

   task automatic test_random();
      logic [31:0] o, e, a, d;
      logic        r, w;
      logic [2:0]  t;
      logic [15:0] offs;
      for (int n = 0; n < 800; n++) begin
         r = ($urandom_range(0, 59) == 0);
         w = 1'($urandom_range(0, 1));
         t = 3'($urandom_range(0, 7));
         d = $urandom;
         if ($urandom_range(0, 3) == 0) begin
            case ($urandom_range(0, 6))
               0: offs = 16'h0000;
               1: offs = 16'h0004;
               2: offs = 16'h0008;
               3: offs = 16'h000C;
               4: offs = 16'h0010;
               5: offs = 16'h0014;
               default: offs = 16'h0002;
            endcase
            a = {16'hFFFF, offs};
            if ($urandom_range(0, 1) == 0) t = 3'd0;
            if (offs == 16'h0008) d = m_cmp - 32'($urandom_range(0, 3));
         end else begin
            a = ($urandom & 32'h7FFF_FC00) | 32'($urandom_range(0, 63));
            if ($urandom_range(0, 1) == 0) t = 3'($urandom_range(0, 4));
         end
         sw_in = 16'($urandom);
         step(r, w, a, d, t, o, e);
         checks++; if (o !== e) begin errors++; $display("FAIL rnd_data n=%0d a=%h t=%0d got %h want %h", n, a, t, o, e); end
         checks++; if (led_out !== m_led) begin errors++; $display("FAIL rnd_led n=%0d got %h want %h", n, led_out, m_led); end
         checks++; if (irq !== m_match) begin errors++; $display("FAIL rnd_irq n=%0d got %b want %b", n, irq, m_match); end
         checks++; if (err !== m_err) begin errors++; $display("FAIL rnd_err n=%0d got %b want %b", n, err, m_err); end
      end
   endtask

   initial begin
      reset = 1'b1; mem_w = 1'b0; addr = 32'h0; wdata = 32'h0; dmt = 3'd0; sw_in = 16'h0;
      for (int i = 0; i < NB; i++) m_ram[i] = 8'h0;
      m_led = 16'h0; m_timer = 32'h0; m_cmp = 32'hFFFF_FFFF; m_match = 1'b0; m_err = 1'b0;
      test_reset();
      test_ram_lanes();
      test_misaligned();
      test_timer();
      test_mmio();
      test_reset_midrun();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
